addsub_accum: RTL
=================

# addsub_accum

Parametrised add/subtract accumulator and the successor to the fixed 16-bit add/sub block. It keeps the same load/enable/direction control. It adds:
- configurable datapath width
- per-operation signed/unsigned and wrap/saturate modes
- a sticky overflow flag
- an operation counter
- a one-cycle result-valid strobe

It sits in the arithmetic datapath, where a controller streams operands into a running total.

## Interface
- WIDTH, 16: accumulator and operand width in bits (≥ 2).
- CNT_W, 8: operation-counter width in bits (≥ 1).

- CLK  in  1  single clock; all state changes on rising edge.
- RST  in  1  reset, synchronous and active-high; one clock, reset synchronous active-high.
- LOAD  in  1  load DATA into accumulator.
- EN  in  1  perform one add/subtract of DATA into accumulator.
- ctl  in  1  direction: 0 = DOUT + DATA, 1 = DOUT − DATA.
- SGN  in  1  0 = unsigned interpretation, 1 = two's-complement signed.
- SAT  in  1  0 = wrap on overflow, 1 = saturate.
- DATA  in  WIDTH  operand / load value.
- DOUT  out  WIDTH  accumulator value (registered).
- COUT  out  1  raw unsigned carry (add) or borrow (sub) of the last EN operation.
- OVF  out  1  sticky overflow, in the mode selected by SGN at each operation.
- VALID  out  1  one-cycle pulse: DOUT updated by LOAD or EN on the previous edge.
- OPCNT  out  CNT_W  number of EN operations since the last LOAD/RST; wraps.

## Operation
- Priority per edge: RST > LOAD > EN > hold.
- **RST:** DOUT=0, COUT=0, OVF=0, VALID=0, OPCNT=0. This applies even when LOAD/EN are asserted, and mid-sequence.
- **LOAD:**
  - DOUT←DATA, COUT←0, OVF←0, OPCNT←0, VALID←1.
  - EN in the same cycle is ignored; no count, no arithmetic.
- **EN (LOAD=0):**
  - Compute raw = DOUT ± DATA in WIDTH+1 bits.
  - c = bit WIDTH of raw (carry for add, borrow for sub).
  - v = signed overflow: operand signs per ctl differ from the result sign as defined by two's-complement rules.
  - Overflow condition o = SGN ? v : c.
  - SAT=0: DOUT←raw[WIDTH-1:0].
  - SAT=1 and o=1:
    - unsigned add → all-ones; unsigned sub → 0.
    - signed: result clamps to max positive (0111…1) when the true result is positive, to min negative (100…0) when it is negative.
  - SAT=1 and o=0: DOUT←raw[WIDTH-1:0].
  - COUT←c always; it is not affected by SAT or SGN.
  - OVF←OVF | o.
  - OPCNT←OPCNT+1 mod 2^CNT_W.
  - VALID←1.
- **Idle (LOAD=0, EN=0):** DOUT, COUT, OVF and OPCNT hold; VALID←0.
- ctl, SGN, SAT and DATA are sampled only on edges where EN or LOAD is acted on. Mode may change between consecutive operations without restriction.
- OVF is cleared only by LOAD or RST.

## Timing
- Latency 1: operands sampled at edge N appear on DOUT/COUT/OVF/OPCNT after edge N.
- VALID is high during cycle N+1 only, unless another operation follows.
- Back-to-back EN every cycle is supported at full throughput. The result of op N is the accumulator input of op N+1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- OPCNT wrap from 2^CNT_W−1 to 0 raises no flag.

## Test plan
1. **Basic add:** RST 2 cycles → all outputs 0. LOAD DATA=0x0001, then 3× EN ctl=0 DATA=0x0002 → DOUT=0x0007, OPCNT=3, COUT=0, OVF=0, VALID high 4 consecutive cycles.
2. **Unsigned add overflow:** SGN=0, LOAD 0xFFFF.
   - EN add 0x0001 with SAT=0 → DOUT=0x0000, COUT=1, OVF=1.
   - Repeat with SAT=1 → DOUT=0xFFFF, COUT=1, OVF=1.
3. **Unsigned sub borrow:** SGN=0, LOAD 0x0004.
   - EN sub 0x0018 with SAT=0 → DOUT=0xFFEC, COUT=1, OVF=1.
   - With SAT=1 → DOUT=0x0000.
   - Then LOAD 0x0010 → OVF=0, COUT=0, OPCNT=0.
4. **Signed saturate:** SGN=1, SAT=1.
   - LOAD 0x7FF0, EN add 0x0020 → DOUT=0x7FFF, OVF=1, COUT=0.
   - LOAD 0x8000, EN sub 0x0001 → DOUT=0x8000, OVF=1, COUT=0.
5. **Priority:**
   - LOAD=1 and EN=1 together with DATA=0x0010 → DOUT=0x0010, OPCNT=0.
   - RST asserted together with LOAD and EN mid-stream → all outputs 0 next cycle.
6. **Counter wrap and hold (CNT_W=4):**
   - 16 EN adds of 0x0001 from LOAD 0 → DOUT=0x0010, OPCNT=0.
   - EN toggled low for 3 cycles → DOUT and OPCNT unchanged, VALID=0 during the idle cycles.

Source files
------------

// File: rtl/addsub_accum.sv
// addsub_accum: parametrised add/subtract accumulator with per-operation
// signed/unsigned and wrap/saturate modes, sticky overflow, an operation
// counter and a one-cycle result-valid strobe.
//
// Ports:
//   CLK    clock, all state changes on the rising edge
//   RST    synchronous active-high reset
//   LOAD   load DATA into the accumulator (wins over EN)
//   EN     accumulate DATA into DOUT (add or subtract)
//   ctl    direction: 0 = DOUT + DATA, 1 = DOUT - DATA
//   SGN    0 = unsigned, 1 = two's-complement signed overflow rules
//   SAT    0 = wrap on overflow, 1 = saturate
//   DATA   operand / load value
//   DOUT   accumulator value
//   COUT   raw carry (add) or borrow (sub) of the last EN operation
//   OVF    sticky overflow, cleared only by LOAD or RST
//   VALID  one-cycle pulse after DOUT was updated by LOAD or EN
//   OPCNT  EN operations since the last LOAD/RST, wrapping
module addsub_accum #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic             EN,
    input  logic             ctl,
    input  logic             SGN,
    input  logic             SAT,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] DOUT,
    output logic             COUT,
    output logic             OVF,
    output logic             VALID,
    output logic [CNT_W-1:0] OPCNT
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   raw_c;
    logic             carry_c;
    logic             sovf_c;
    logic             ovf_c;
    logic [WIDTH-1:0] result_c;

    // Arithmetic, overflow detection and saturation for one EN operation.
    always_comb begin
        raw_c    = '0;
        carry_c  = 1'b0;
        sovf_c   = 1'b0;
        ovf_c    = 1'b0;
        result_c = '0;

        if (ctl) begin
            raw_c = {1'b0, DOUT} - {1'b0, DATA};
        end else begin
            raw_c = {1'b0, DOUT} + {1'b0, DATA};
        end
        carry_c = raw_c[WIDTH];

        // Signed overflow: effective operand signs agree but the result sign
        // differs from the accumulator sign. Subtraction flips DATA's sign.
        if (ctl) begin
            sovf_c = (DOUT[MSB] != DATA[MSB]) && (raw_c[MSB] != DOUT[MSB]);
        end else begin
            sovf_c = (DOUT[MSB] == DATA[MSB]) && (raw_c[MSB] != DOUT[MSB]);
        end

        ovf_c    = SGN ? sovf_c : carry_c;
        result_c = raw_c[WIDTH-1:0];

        if (SAT && ovf_c) begin
            if (SGN) begin
                // On signed overflow the true result has the accumulator's sign.
                result_c = DOUT[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                result_c = ctl ? '0 : '1;
            end
        end
    end

    // State update: RST > LOAD > EN > hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT  <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
            VALID <= 1'b0;
            OPCNT <= '0;
        end else if (LOAD) begin
            DOUT  <= DATA;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
            VALID <= 1'b1;
            OPCNT <= '0;
        end else if (EN) begin
            DOUT  <= result_c;
            COUT  <= carry_c;
            OVF   <= OVF | ovf_c;
            VALID <= 1'b1;
            OPCNT <= OPCNT + CNT_W'(1);
        end else begin
            VALID <= 1'b0;
        end
    end

endmodule
